// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and its front-end sequencer: opcodes, FSM encoding and
// the legal-opcode check used by the optional ALU_SEQ_OPCODE_CHECK_EN build.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // Encoding is visible on the debug LEDs, so values are fixed.
    typedef enum logic [2:0] {
        StWaitA  = 3'd0,
        StWaitB  = 3'd1,
        StWaitOp = 3'd2,
        StExec   = 3'd3,
        StShow   = 3'd4
    } state_t;

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous push-button followed by a delay flop;
// emits a single-cycle pulse on each rising edge, however long the button is held.
module btn_edge_sync (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_edge
);

    logic sync1_q, sync2_q, delay_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            delay_q <= 1'b0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            delay_q <= sync2_q;
        end
    end

    assign o_edge = sync2_q & ~delay_q;

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for the board ALU: loads A, B and opcode from switches on button
// edges, runs one ALU cycle and latches the result. ALU_SEQ_OPCODE_CHECK_EN rejects bad opcodes.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA = 4,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned NB_SW   = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    input  logic [NB_DATA-1:0] i_result,
    output logic [NB_DATA-1:0] o_leds,
`ifdef ALU_SEQ_OPCODE_CHECK_EN
    output logic               o_op_err,
`endif
    output logic [2:0]         o_state,
    output logic               o_done
);

    logic edge_a, edge_b, edge_op;

    btn_edge_sync u_sync_a  (.clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_a),  .o_edge(edge_a));
    btn_edge_sync u_sync_b  (.clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_b),  .o_edge(edge_b));
    btn_edge_sync u_sync_op (.clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op), .o_edge(edge_op));

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] dato_a_q, dato_a_d;
    logic [NB_DATA-1:0] dato_b_q, dato_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] leds_q, leds_d;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
    logic               op_err_q, op_err_d;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StWaitA;
            dato_a_q <= '0;
            dato_b_q <= '0;
            op_q     <= NB_OP'(OP_ADD);
            leds_q   <= '0;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
            op_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dato_a_q <= dato_a_d;
            dato_b_q <= dato_b_d;
            op_q     <= op_d;
            leds_q   <= leds_d;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
            op_err_q <= op_err_d;
`endif
        end
    end

    // Edges not expected in the current state simply fall through and are lost.
    always_comb begin
        state_d  = state_q;
        dato_a_d = dato_a_q;
        dato_b_d = dato_b_q;
        op_d     = op_q;
        leds_d   = leds_q;
        o_done   = 1'b0;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
        op_err_d = 1'b0;
`endif
        case (state_q)
            StWaitA, StShow: begin
                if (edge_a) begin
                    dato_a_d = i_sw[NB_DATA-1:0];
                    state_d  = StWaitB;
                end
            end
            StWaitB: begin
                if (edge_b) begin
                    dato_b_d = i_sw[NB_DATA-1:0];
                    state_d  = StWaitOp;
                end
            end
            StWaitOp: begin
                if (edge_op) begin
`ifdef ALU_SEQ_OPCODE_CHECK_EN
                    if (opcode_legal(6'(i_sw[NB_OP-1:0]))) begin
                        op_d    = i_sw[NB_OP-1:0];
                        state_d = StExec;
                    end else begin
                        op_err_d = 1'b1;
                    end
`else
                    op_d    = i_sw[NB_OP-1:0];
                    state_d = StExec;
`endif
                end
            end
            StExec: begin
                // Operands have been registered for a full cycle, so i_result is settled.
                leds_d  = i_result;
                o_done  = 1'b1;
                state_d = StShow;
            end
            default: state_d = StWaitA;
        endcase
    end

    if (NB_SW > NB_OP) begin : g_sw_unused
        logic unused_sw;
        assign unused_sw = ^i_sw[NB_SW-1:NB_OP];
    end

    assign o_datoA     = dato_a_q;
    assign o_datoB     = dato_b_q;
    assign o_operation = op_q;
    assign o_leds      = leds_q;
    assign o_state     = 3'(state_q);
`ifdef ALU_SEQ_OPCODE_CHECK_EN
    assign o_op_err    = op_err_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random button traffic, checked every
// cycle against a behavioural model of the sequencer and a stub ALU.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_sw;
    logic       i_btn_a, i_btn_b, i_btn_op;
    logic [3:0] o_datoA, o_datoB, i_result, o_leds;
    logic [5:0] o_operation;
    logic [2:0] o_state;
    logic       o_done;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
    logic       o_op_err;
`endif

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_sw       (i_sw),
        .i_btn_a    (i_btn_a),
        .i_btn_b    (i_btn_b),
        .i_btn_op   (i_btn_op),
        .o_datoA    (o_datoA),
        .o_datoB    (o_datoB),
        .o_operation(o_operation),
        .i_result   (i_result),
        .o_leds     (o_leds),
`ifdef ALU_SEQ_OPCODE_CHECK_EN
        .o_op_err   (o_op_err),
`endif
        .o_state    (o_state),
        .o_done     (o_done)
    );

    function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b,
                                       input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b000011: return 4'($signed(a) >>> b);
            6'b000010: return a >> b;
            6'b100111: return ~(a | b);
            default:   return 4'h0;
        endcase
    endfunction

    always_comb i_result = alu(o_datoA, o_datoB, o_operation);

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
    endfunction

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0..4 = waiting A, B, opcode, executing, showing.
    int         m_phase;
    logic [3:0] m_a, m_b, m_leds;
    logic [5:0] m_op;
    logic       m_err;
    logic [2:0] seen1, seen2, seen3;  // button levels sampled 1, 2 and 3 edges ago
    logic [2:0] ev;

    always @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_phase = 0; m_a = 0; m_b = 0; m_op = 6'h20; m_leds = 0; m_err = 0;
            seen1 = 0; seen2 = 0; seen3 = 0;
        end else begin
            // A level first sampled two edges ago and absent three edges ago acts now.
            ev = seen2 & ~seen3;
            seen3 = seen2; seen2 = seen1; seen1 = {i_btn_op, i_btn_b, i_btn_a};
            m_err = 0;
            case (m_phase)
                0, 4: if (ev[0]) begin m_a = i_sw[3:0]; m_phase = 1; end
                1:    if (ev[1]) begin m_b = i_sw[3:0]; m_phase = 2; end
                2: if (ev[2]) begin
`ifdef ALU_SEQ_OPCODE_CHECK_EN
                    if (legal(i_sw[5:0])) begin m_op = i_sw[5:0]; m_phase = 3; end
                    else m_err = 1;
`else
                    m_op = i_sw[5:0]; m_phase = 3;
`endif
                end
                3: begin m_leds = alu(m_a, m_b, m_op); m_phase = 4; end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (o_done) done_cnt++;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
        if (o_op_err) err_cnt++;
`endif
        if (chk_en) begin
            check("state", int'(o_state), m_phase);
            check("datoA", int'(o_datoA), int'(m_a));
            check("datoB", int'(o_datoB), int'(m_b));
            check("operation", int'(o_operation), int'(m_op));
            check("leds", int'(o_leds), int'(m_leds));
            check("done", int'(o_done), int'(m_phase == 3));
`ifdef ALU_SEQ_OPCODE_CHECK_EN
            check("op_err", int'(o_op_err), int'(m_err));
`endif
        end
    end

    // Drive sw, hold the masked buttons for 'hold' cycles, then let the edges settle.
    task automatic press(input logic [2:0] mask, input logic [7:0] sw, input int hold);
        @(posedge clk); #2;
        i_sw = sw;
        {i_btn_op, i_btn_b, i_btn_a} = mask;
        repeat (hold) @(posedge clk);
        #2;
        {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        i_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n = 1'b0; i_sw = 8'h00;
        i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_state", int'(o_state), 0);
        check("rst_operation", int'(o_operation), 'h20);
        check("rst_leds", int'(o_leds), 0);
        i_rst_n = 1'b1;

        // 3 + 5 with ADD
        press(3'b001, 8'h03, 1);
        press(3'b010, 8'h05, 1);
        press(3'b100, 8'h20, 1);
        check("add_leds", int'(o_leds), 8);
        check("add_state", int'(o_state), 4);
        check("add_done_pulses", done_cnt, 1);

        // Out-of-order B/opcode presses are discarded while waiting for A.
        do_reset();
        press(3'b010, 8'h0F, 1);
        press(3'b100, 8'h0F, 1);
        check("ooo_datoB", int'(o_datoB), 0);
        check("ooo_operation", int'(o_operation), 'h20);
        check("ooo_state", int'(o_state), 0);
        press(3'b001, 8'h0C, 1);
        press(3'b010, 8'h0A, 1);
        press(3'b100, 8'h24, 1);
        check("and_leds", int'(o_leds), 8);

        // New operation straight from the result display; result held until execution.
        press(3'b001, 8'h09, 1);
        check("show_a_state", int'(o_state), 1);
        check("show_leds_held", int'(o_leds), 8);
        press(3'b010, 8'h01, 1);
        press(3'b100, 8'h22, 1);
        check("sub_leds", int'(o_leds), 8);

        // Held button gives a single capture.
        press(3'b001, 8'h06, 20);
        check("hold_state", int'(o_state), 1);
        check("hold_datoA", int'(o_datoA), 6);

        // Asynchronous reset while waiting for the opcode.
        press(3'b010, 8'h02, 1);
        check("pre_rst_state", int'(o_state), 2);
        @(posedge clk); #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_state", int'(o_state), 0);
        check("arst_datoA", int'(o_datoA), 0);
        check("arst_datoB", int'(o_datoB), 0);
        check("arst_operation", int'(o_operation), 'h20);
        check("arst_leds", int'(o_leds), 0);
        check("arst_done", int'(o_done), 0);
        @(posedge clk); #2;
        i_rst_n = 1'b1;

`ifdef ALU_SEQ_OPCODE_CHECK_EN
        err_cnt = 0;
        press(3'b001, 8'h03, 1);
        press(3'b010, 8'h05, 1);
        press(3'b100, 8'h3F, 1);
        check("bad_op_err_pulses", err_cnt, 1);
        check("bad_op_state", int'(o_state), 2);
        check("bad_op_operation", int'(o_operation), 'h20);
        press(3'b100, 8'h27, 1);
        check("nor_leds", int'(o_leds), 8);
`endif

        // Random traffic: mixed and simultaneous buttons, occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            press(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(1, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
